// File: rtl/floo_serial_link_chan_arbiter.sv
// Round-robin merge of the narrow request, narrow response and wide channels into one tagged,
// registered flit stream. The optional remote-buffer credit counters are built when
// SERIAL_LINK_ARB_CREDIT_EN is defined.
module floo_serial_link_chan_arbiter #(
  parameter int unsigned NarrowReqWidth = 64,
  parameter int unsigned NarrowRspWidth = 64,
  parameter int unsigned WideWidth      = 576,
  parameter int unsigned NumCredits     = 8,
  localparam int unsigned NarrowMax     = (NarrowReqWidth > NarrowRspWidth) ?
                                          NarrowReqWidth : NarrowRspWidth,
  localparam int unsigned DataWidth     = (NarrowMax > WideWidth) ? NarrowMax : WideWidth,
  localparam int unsigned CreditWidth   = $clog2(NumCredits + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       narrow_req_valid_i,
  output logic                       narrow_req_ready_o,
  input  logic [NarrowReqWidth-1:0]  narrow_req_data_i,
  input  logic                       narrow_rsp_valid_i,
  output logic                       narrow_rsp_ready_o,
  input  logic [NarrowRspWidth-1:0]  narrow_rsp_data_i,
  input  logic                       wide_valid_i,
  output logic                       wide_ready_o,
  input  logic [WideWidth-1:0]       wide_data_i,
  input  logic [2:0]                 credit_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [1:0]                 out_chan_o,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [3*CreditWidth-1:0]   credits_o,
  output logic                       credit_err_o
);

  logic [2:0]                valid, eligible, has_credit, gnt;
  logic [1:0]                gnt_idx;
  logic [1:0]                order [3];
  logic [2:0][DataWidth-1:0] data_pad;
  logic                      load;

  logic                      out_valid_q;
  logic [1:0]                out_chan_q;
  logic [DataWidth-1:0]      out_data_q;
  logic [1:0]                rr_q;

  assign valid       = {wide_valid_i, narrow_rsp_valid_i, narrow_req_valid_i};
  assign data_pad[0] = DataWidth'(narrow_req_data_i);
  assign data_pad[1] = DataWidth'(narrow_rsp_data_i);
  assign data_pad[2] = DataWidth'(wide_data_i);
  assign eligible    = valid & has_credit;
  assign load        = !out_valid_q || out_ready_i;

  // Priority order starts at the channel after the last accepted grant.
  always_comb begin
    order   = '{2'd0, 2'd1, 2'd2};
    gnt     = '0;
    gnt_idx = '0;
    case (rr_q)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    for (int i = 2; i >= 0; i--) begin
      if (eligible[order[i]]) gnt_idx = order[i];
    end
    if (rst_ni && load && (|eligible)) gnt[gnt_idx] = 1'b1;
  end

  assign narrow_req_ready_o = gnt[0];
  assign narrow_rsp_ready_o = gnt[1];
  assign wide_ready_o       = gnt[2];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= 2'd0;
      out_data_q  <= '0;
      rr_q        <= 2'd2;
    end else if (load) begin
      out_valid_q <= |gnt;
      // Stale payload is kept on drain.
      if (|gnt) begin
        out_chan_q <= gnt_idx;
        out_data_q <= data_pad[gnt_idx];
        rr_q       <= gnt_idx;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_chan_o  = out_chan_q;
  assign out_data_o  = out_data_q;

`ifdef SERIAL_LINK_ARB_CREDIT_EN
  logic [2:0][CreditWidth-1:0] cnt_q;
  logic                        err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {3{CreditWidth'(NumCredits)}};
      err_q <= 1'b0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (gnt[n] && !credit_i[n]) begin
          cnt_q[n] <= cnt_q[n] - CreditWidth'(1);
        end else if (credit_i[n] && !gnt[n]) begin
          // A return beyond the buffer depth is dropped and flagged.
          if (cnt_q[n] == CreditWidth'(NumCredits)) err_q <= 1'b1;
          else                                      cnt_q[n] <= cnt_q[n] + CreditWidth'(1);
        end
      end
    end
  end

  always_comb begin
    has_credit = '0;
    for (int n = 0; n < 3; n++) has_credit[n] = (cnt_q[n] != '0);
  end

  assign credits_o    = cnt_q;
  assign credit_err_o = err_q;
`else
  logic unused_credit;
  assign unused_credit = ^credit_i;
  assign has_credit    = '1;
  assign credits_o     = {3{CreditWidth'(NumCredits)}};
  assign credit_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_floo_serial_link_chan_arbiter.sv
// Self-checking bench for floo_serial_link_chan_arbiter: directed table, hand sequences and a
// randomized run against a cycle-level behavioural model.
module tb_floo_serial_link_chan_arbiter;

  localparam int unsigned NRW = 64;
  localparam int unsigned NSW = 64;
  localparam int unsigned WW  = 576;
  localparam int unsigned NC  = 8;
  localparam int unsigned DW  = 576;
  localparam int unsigned CW  = 4;
`ifdef SERIAL_LINK_ARB_CREDIT_EN
  localparam bit CredEn = 1'b1;
`else
  localparam bit CredEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      valid = '0;
  logic [NRW-1:0]  d0 = '0;
  logic [NSW-1:0]  d1 = '0;
  logic [WW-1:0]   d2 = '0;
  logic [2:0]      credit = '0;
  logic            out_ready = 1'b0;
  logic [2:0]      ready;
  logic            out_valid;
  logic [1:0]      out_chan;
  logic [DW-1:0]   out_data;
  logic [3*CW-1:0] credits;
  logic            credit_err;

  always #5 clk = ~clk;

  floo_serial_link_chan_arbiter dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .narrow_req_valid_i (valid[0]),
    .narrow_req_ready_o (ready[0]),
    .narrow_req_data_i  (d0),
    .narrow_rsp_valid_i (valid[1]),
    .narrow_rsp_ready_o (ready[1]),
    .narrow_rsp_data_i  (d1),
    .wide_valid_i       (valid[2]),
    .wide_ready_o       (ready[2]),
    .wide_data_i        (d2),
    .credit_i           (credit),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_chan_o         (out_chan),
    .out_data_o         (out_data),
    .credits_o          (credits),
    .credit_err_o       (credit_err)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  int            m_last = 2;
  bit            m_ov = 1'b0;
  int            m_chan = 0;
  logic [DW-1:0] m_data = '0;
  int            m_cred [3] = '{NC, NC, NC};
  bit            m_err = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] pad(input int c);
    if (c == 0) return DW'(d0);
    if (c == 1) return DW'(d1);
    return DW'(d2);
  endfunction

  function automatic int winner();
    int c;
    if (!rst_n) return -1;
    if (m_ov && !out_ready) return -1;
    for (int k = 1; k <= 3; k++) begin
      c = (m_last + k) % 3;
      if (valid[c] && (!CredEn || m_cred[c] > 0)) return c;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] cred_of(input int n);
    logic [3*CW-1:0] v;
    v = credits;
    return DW'(v[n*CW +: CW]);
  endfunction

  // Call with inputs set shortly after a rising edge; returns one cycle later, 1 after the edge.
  task automatic cycle(output logic [2:0] r_seen);
    int w;
    logic [2:0] exp_r;
    logic [DW-1:0] pw;
    #1;
    w = winner();
    exp_r = '0;
    if (w >= 0) exp_r[w] = 1'b1;
    r_seen = ready;
    chk("ready", DW'(ready), DW'(exp_r));
    pw = (w >= 0) ? pad(w) : '0;
    @(posedge clk);
    if (!rst_n) begin
      m_ov = 1'b0; m_chan = 0; m_data = '0; m_last = 2; m_err = 1'b0;
      for (int n = 0; n < 3; n++) m_cred[n] = NC;
    end else begin
      if (m_ov == 1'b0 || out_ready) begin
        m_ov = (w >= 0);
        if (w >= 0) begin
          m_chan = w; m_data = pw; m_last = w;
        end
      end
      if (CredEn) begin
        for (int n = 0; n < 3; n++) begin
          if (w == n && !credit[n]) m_cred[n]--;
          else if (credit[n] && w != n) begin
            if (m_cred[n] == NC) m_err = 1'b1;
            else m_cred[n]++;
          end
        end
      end
    end
    #1;
    chk("out_valid", DW'(out_valid), DW'(m_ov));
    chk("out_chan", DW'(out_chan), DW'(m_chan));
    chk("out_data", out_data, m_data);
    for (int n = 0; n < 3; n++) chk("credits", cred_of(n), DW'(m_cred[n]));
    chk("credit_err", DW'(credit_err), DW'(m_err));
  endtask

  task automatic do_reset();
    logic [2:0] r;
    rst_n = 1'b0; valid = 3'b111; credit = '0; out_ready = 1'b1;
    cycle(r);
    chk("rst_ready", DW'(r), DW'(3'b000));
    cycle(r);
    rst_n = 1'b1; valid = '0;
  endtask

  typedef struct {
    logic [2:0] v;
    logic       rdy;
    logic [2:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_chan;
  } vec_t;

  localparam logic [NRW-1:0] K0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [NSW-1:0] K1 = 64'hFEDC_BA98_7654_3210;

  function automatic logic [DW-1:0] kdata(input logic [1:0] c);
    if (c == 2'd0) return DW'(K0);
    if (c == 2'd1) return DW'(K1);
    return DW'(d2);
  endfunction

  function automatic logic [WW-1:0] rand_wide();
    logic [WW-1:0] v;
    for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    vec_t tbl [11];
    logic [2:0] r;

    tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0};
    tbl[4]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0};
    tbl[5]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0};
    tbl[6]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1};
    tbl[7]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd1};
    tbl[8]  = '{3'b100, 1'b0, 3'b100, 1'b1, 2'd2};
    tbl[9]  = '{3'b011, 1'b0, 3'b000, 1'b1, 2'd2};
    tbl[10] = '{3'b011, 1'b1, 3'b001, 1'b1, 2'd0};

    // Reset values
    do_reset();
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_chan", DW'(out_chan), DW'(0));
    chk("rst_out_data", out_data, '0);
    for (int n = 0; n < 3; n++) chk("rst_credits", cred_of(n), DW'(NC));
    chk("rst_credit_err", DW'(credit_err), DW'(0));

    // Single narrow request flit
    valid = 3'b001; d0 = 64'hA5; out_ready = 1'b1;
    cycle(r);
    chk("single_ready", DW'(r[0]), DW'(1));
    chk("single_valid", DW'(out_valid), DW'(1));
    chk("single_chan", DW'(out_chan), DW'(0));
    chk("single_data", out_data, DW'(64'hA5));
    chk("single_credit", cred_of(0), DW'(CredEn ? NC - 1 : NC));

    // Round robin, backpressure, drain
    do_reset();
    d0 = K0; d1 = K1; d2 = rand_wide();
    for (int i = 0; i < 11; i++) begin
      valid = tbl[i].v; out_ready = tbl[i].rdy;
      cycle(r);
      chk($sformatf("tbl%0d_ready", i), DW'(r), DW'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_valid", i), DW'(out_valid), DW'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_chan", i), DW'(out_chan), DW'(tbl[i].exp_chan));
      chk($sformatf("tbl%0d_data", i), out_data, kdata(tbl[i].exp_chan));
    end

    // Wide credit exhaustion and return
    do_reset();
    valid = 3'b100; out_ready = 1'b1;
    if (CredEn) begin
      for (int i = 0; i < 8; i++) begin
        cycle(r);
        chk("wide_ready", DW'(r[2]), DW'(1));
      end
      chk("wide_empty", cred_of(2), DW'(0));
      credit = 3'b100;
      cycle(r);
      chk("wide_stall", DW'(r[2]), DW'(0));
      chk("wide_ret", cred_of(2), DW'(1));
      credit = 3'b000;
      cycle(r);
      chk("wide_one", DW'(r[2]), DW'(1));
      chk("wide_used", cred_of(2), DW'(0));
      cycle(r);
      chk("wide_stall2", DW'(r[2]), DW'(0));
      valid = 3'b000; credit = 3'b100;
      cycle(r);
      valid = 3'b100;
      cycle(r);
      chk("wide_same_ready", DW'(r[2]), DW'(1));
      chk("wide_same_cnt", cred_of(2), DW'(1));
      credit = 3'b000;
    end else begin
      for (int i = 0; i < 20; i++) begin
        d2 = rand_wide();
        cycle(r);
        chk("nocred_ready", DW'(r[2]), DW'(1));
        chk("nocred_data", out_data, DW'(d2));
        chk("nocred_cnt", cred_of(2), DW'(NC));
        chk("nocred_err", DW'(credit_err), DW'(0));
      end
    end

    // Credit overflow is sticky
    do_reset();
    credit = 3'b010;
    cycle(r);
    credit = 3'b000;
    chk("ovf_err", DW'(credit_err), DW'(CredEn));
    chk("ovf_cnt", cred_of(1), DW'(NC));
    repeat (3) cycle(r);
    chk("ovf_sticky", DW'(credit_err), DW'(CredEn));

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      valid     = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 3; n++) credit[n] = ($urandom_range(0, 5) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      d2 = rand_wide();
      cycle(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
